// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter: Stein engine state encoding and default sizes.
package gcd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_NREQ  = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t CHECK  = 3'd1;
  localparam state_t FACTOR = 3'd2;
  localparam state_t ODDA   = 3'd3;
  localparam state_t REDUCE = 3'd4;
  localparam state_t DONE   = 3'd5;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Request/response bundle between client blocks and the shared GCD arbiter.
interface gcd_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic                  busy;
  logic [IDW-1:0]        grant_id;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_data, busy, grant_id
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_data, busy, grant_id
  );
endinterface

// File: rtl/gcd_stein_core.sv
// Iterative binary (Stein) GCD engine: one reduction step per clock, done pulse in DONE.
module gcd_stein_core
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          k_d     = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (a_q == '0) begin
          result_d = b_q;
          state_d  = DONE;
        end else if (b_q == '0) begin
          result_d = a_q;
          state_d  = DONE;
        end else begin
          state_d = FACTOR;
        end
      end
      FACTOR: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 1'b1;
        end else begin
          state_d = ODDA;
        end
      end
      ODDA: begin
        if (!a_q[0]) a_d = a_q >> 1;
        else         state_d = REDUCE;
      end
      REDUCE: begin
        // a stays odd from here on, so a-b or b-a is always even and non-negative
        if (b_q == '0) begin
          result_d = a_q << k_q;
          state_d  = DONE;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = b_q;
          b_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one Stein GCD engine between NREQ requesters.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned NREQ  = DEFAULT_NREQ,
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned IDW   = 2
) (
  input logic          clk,
  input logic          reset,
  gcd_arbiter_if.slave bus
);

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   gnt_idx, cand;
  logic             gnt_found;
  logic             start;
  logic             core_busy, core_done;
  logic [WIDTH-1:0] core_result, sel_a, sel_b;

  // First requester at or after rr_ptr, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign start = !core_busy && gnt_found;
  assign sel_a = bus.req_a[32'(gnt_idx) * WIDTH +: WIDTH];
  assign sel_b = bus.req_b[32'(gnt_idx) * WIDTH +: WIDTH];

  always_comb begin
    bus.req_ready = '0;
    if (start) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (start) grant_d = gnt_idx;
    if (core_done) rr_ptr_d = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  gcd_stein_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .a_i      (sel_a),
    .b_i      (sel_b),
    .busy_o   (core_busy),
    .done_o   (core_done),
    .result_o (core_result)
  );

  always_comb begin
    bus.resp_valid = '0;
    if (core_done) bus.resp_valid[grant_q] = 1'b1;
  end

  assign bus.resp_data = core_result;
  assign bus.busy      = core_busy;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: acceptances push expected responses, a monitor pops and checks.
module tb_gcd_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;
  localparam int          MAX_LAT = 4 * WIDTH + 4;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         t;
    bit         zero;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  gcd_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic       vld[NREQ];
  logic [7:0] op_a[NREQ];
  logic [7:0] op_b[NREQ];
  logic [7:0] exp_res[NREQ];

  exp_t sb[$];
  int   glog[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  int   mon_lat;
  int   mon_id;

  always_comb begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = vld[i];
      bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  // Monitor: busy vs outstanding work, responses against the scoreboard, then new acceptances
  always @(negedge clk) begin
    if (!reset) begin
      chk(bus.busy == (sb.size() != 0), "busy", bus.busy, sb.size() != 0);
      if (bus.resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_resp", bus.resp_valid, 0);
        end else begin
          mon_e   = sb.pop_front();
          mon_lat = cyc - mon_e.t;
          chk(bus.resp_valid == 4'(1 << mon_e.id), "resp_valid", bus.resp_valid,
              4'(1 << mon_e.id));
          chk(bus.resp_data == mon_e.data, "resp_data", bus.resp_data, mon_e.data);
          chk(bus.grant_id == 2'(mon_e.id), "grant_id", bus.grant_id, mon_e.id);
          if (mon_e.zero) chk(mon_lat == 2, "latency_zero", mon_lat, 2);
          else chk(mon_lat > 2 && mon_lat <= MAX_LAT, "latency_bound", mon_lat, MAX_LAT);
        end
      end
      if (bus.req_ready != '0) begin
        chk($onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0),
            "ready_onehot", bus.req_ready, bus.req_valid);
        mon_id = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) mon_id = i;
        mon_e.id   = mon_id;
        mon_e.data = exp_res[mon_id];
        mon_e.t    = cyc;
        mon_e.zero = (op_a[mon_id] == 0) || (op_b[mon_id] == 0);
        sb.push_back(mon_e);
        glog.push_back(mon_id);
      end
    end
  end

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    op_a[id]    = a;
    op_b[id]    = b;
    exp_res[id] = e;
    vld[id]     = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, "accept_timeout", id, -1);
    @(posedge clk);
    #1;
    vld[id] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      chk(1'b0, "drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_grants(input int n);
    for (int c = 0; c < 2000 && glog.size() < n; c++) @(negedge clk);
    if (glog.size() < n) chk(1'b0, "grant_timeout", glog.size(), n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    chk(bus.resp_valid == '0, {tag, "_resp_valid"}, bus.resp_valid, 0);
    chk(bus.resp_data == '0, {tag, "_resp_data"}, bus.resp_data, 0);
    chk(bus.busy == 1'b0, {tag, "_busy"}, bus.busy, 0);
    chk(bus.grant_id == '0, {tag, "_grant_id"}, bus.grant_id, 0);
    chk(bus.req_ready == '0, {tag, "_req_ready"}, bus.req_ready, 0);
  endtask

  task automatic rand_driver(input int id);
    logic [7:0] a, b;
    for (int n = 0; n < 500; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a = 8'd0;
      if ($urandom_range(0, 15) == 0) b = 8'd0;
      issue(id, a, b, gcd_ref(a, b));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int exp_order[7];
    exp_order = '{0, 2, 0, 2, 0, 1, 2};
    for (int i = 0; i < NREQ; i++) begin
      vld[i]     = 1'b0;
      op_a[i]    = '0;
      op_b[i]    = '0;
      exp_res[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_quiet("reset");

    // Directed vectors, expected values worked by hand
    issue(0, 8'd48, 8'd18, 8'd6);
    issue(1, 8'd0, 8'd35, 8'd35);
    issue(1, 8'd0, 8'd0, 8'd0);
    issue(3, 8'd255, 8'd255, 8'd255);
    issue(3, 8'd128, 8'd192, 8'd64);
    issue(3, 8'd200, 8'd150, 8'd50);
    drain();

    // Abort in REDUCE: no response may appear, everything clears
    issue(0, 8'd240, 8'd36, 8'd12);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    check_quiet("abort");
    issue(2, 8'd240, 8'd36, 8'd12);
    drain();

    // Round-robin with 0 and 2 held, late request from 1
    do_reset();
    glog.delete();
    op_a[0] = 8'd12; op_b[0] = 8'd8;  exp_res[0] = 8'd4;
    op_a[2] = 8'd9;  op_b[2] = 8'd6;  exp_res[2] = 8'd3;
    op_a[1] = 8'd10; op_b[1] = 8'd4;  exp_res[1] = 8'd2;
    @(posedge clk);
    #1;
    vld[0] = 1'b1;
    vld[2] = 1'b1;
    wait_grants(5);
    @(posedge clk);
    #1 vld[1] = 1'b1;
    wait_grants(6);
    @(posedge clk);
    #1 vld[1] = 1'b0;
    wait_grants(7);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    vld[2] = 1'b0;
    drain();
    chk(glog.size() == 7, "grant_count", glog.size(), 7);
    for (int i = 0; i < 7 && i < glog.size(); i++)
      chk(glog[i] == exp_order[i], $sformatf("grant_order_%0d", i), glog[i], exp_order[i]);

    // Random sweep, all requesters competing
    fork
      rand_driver(0);
      rand_driver(1);
      rand_driver(2);
      rand_driver(3);
    join
    drain();
    chk(sb.size() == 0, "sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
